// File: rtl/layer_normalizer_pkg.sv
// norm_pkg: shared state encoding and width helpers for the layer normaliser
package norm_pkg;
    typedef enum logic [1:0] {LOAD, DIV, OUT} norm_state_t;
    function automatic int ch_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int sum_w(int n_ch, int data_w);
        return data_w + ch_w(n_ch);
    endfunction
    function automatic int q_w(int frac_w);
        return frac_w + 1;
    endfunction
endpackage

// File: rtl/layer_normalizer_if.sv
// layer_normalizer_if: input/output streams of the normaliser; out_argmax exists only with NORM_ARGMAX_EN
interface layer_normalizer_if #(
    parameter int DATA_W = 16,
    parameter int Q_W = 16
`ifdef NORM_ARGMAX_EN
    , parameter int CH_W = 4
`endif
);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [Q_W-1:0] out_data;
    logic out_last;
    logic zero_sum;
`ifdef NORM_ARGMAX_EN
    logic [CH_W-1:0] out_argmax;
`endif
    modport master (
        output in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, out_last, zero_sum
`ifdef NORM_ARGMAX_EN
        , input out_argmax
`endif
    );
    modport slave (
        input in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, zero_sum
`ifdef NORM_ARGMAX_EN
        , output out_argmax
`endif
    );
endinterface

// File: rtl/norm_serial_div.sv
// norm_serial_div: restoring divider, one quotient bit per cycle; caller guarantees the quotient fits Q_W bits
module norm_serial_div #(
    parameter int N_W = 31,
    parameter int D_W = 20,
    parameter int Q_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic busy,
    output logic done,
    output logic [Q_W-1:0] quotient
);
    localparam int C_W = $clog2(Q_W + 1);
    logic [D_W-1:0] rem;
    logic [Q_W-1:0] qr;
    logic [C_W-1:0] cnt;
    logic [D_W:0] trial;
    logic ge;
    // upper dividend bits seed the remainder: they are below the divisor when the quotient fits
    assign trial = {rem, qr[Q_W-1]};
    assign ge = trial >= {1'b0, divisor};
    assign busy = cnt != '0;
    assign done = cnt == C_W'(1);
    assign quotient = qr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            qr <= '0;
            cnt <= '0;
        end else if (start && !busy) begin
            rem <= D_W'(dividend >> Q_W);
            qr <= dividend[Q_W-1:0];
            cnt <= C_W'(Q_W);
        end else if (busy) begin
            rem <= ge ? D_W'(trial - {1'b0, divisor}) : trial[D_W-1:0];
            qr <= {qr[Q_W-2:0], ge};
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/layer_normalizer.sv
// layer_normalizer: buffers a frame of activations and streams each one divided by the frame sum
// Optional argmax reporting is enabled by defining NORM_ARGMAX_EN.
module layer_normalizer
    import norm_pkg::*;
#(
    parameter int N_CH = 10,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15
) (
    input logic clk,
    input logic rst,
    layer_normalizer_if.slave bus
);
    localparam int CH_W = ch_w(N_CH);
    localparam int SUM_W = sum_w(N_CH, DATA_W);
    localparam int Q_W = q_w(FRAC_W);
    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
    norm_state_t state, state_n;
    logic [CH_W-1:0] ch;
    logic [SUM_W-1:0] sum;
    logic [N_CH-1:0][DATA_W-1:0] frame;
    logic zero_q, skip;
    logic in_hs, out_hs, last_ch, sum_zero;
    logic div_start, div_busy, div_done;
    logic [Q_W-1:0] quot;
    assign in_hs = bus.in_valid && state == LOAD;
    assign out_hs = bus.out_ready && state == OUT;
    assign last_ch = ch == LAST;
    assign sum_zero = sum == '0;
    assign div_start = state == DIV && !div_busy && !sum_zero;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else state <= state_n;
    end
    // a zero-sum DIV still spends two edges (skip toggles) so output pacing stays regular
    always_comb begin
        state_n = state;
        if (in_hs && last_ch) state_n = DIV;
        if (state == DIV && (sum_zero ? skip : div_done)) state_n = OUT;
        if (out_hs) state_n = last_ch ? LOAD : DIV;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
            sum <= '0;
            frame <= '0;
            zero_q <= 1'b0;
            skip <= 1'b0;
        end else begin
            skip <= state == DIV && sum_zero && !skip;
            if (state == DIV && sum_zero) zero_q <= 1'b1;
            if (in_hs) begin
                frame[ch] <= bus.in_data;
                sum <= sum + SUM_W'(bus.in_data);
                ch <= last_ch ? '0 : ch + 1'b1;
            end
            if (out_hs) begin
                ch <= last_ch ? '0 : ch + 1'b1;
                if (last_ch) begin
                    sum <= '0;
                    zero_q <= 1'b0;
                end
            end
        end
    end
    norm_serial_div #(.N_W(DATA_W + FRAC_W), .D_W(SUM_W), .Q_W(Q_W)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .dividend({frame[ch], {FRAC_W{1'b0}}}),
        .divisor(sum),
        .busy(div_busy),
        .done(div_done),
        .quotient(quot)
    );
`ifdef NORM_ARGMAX_EN
    logic [DATA_W-1:0] max_v;
    logic [CH_W-1:0] arg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_v <= '0;
            arg <= '0;
        end else if (in_hs && (ch == '0 || bus.in_data > max_v)) begin
            max_v <= bus.in_data;
            arg <= ch;
        end
    end
    assign bus.out_argmax = arg;
`endif
    assign bus.in_ready = state == LOAD;
    assign bus.out_valid = state == OUT;
    assign bus.out_last = state == OUT && last_ch;
    assign bus.out_data = (state == OUT && !zero_q) ? quot : '0;
    assign bus.zero_sum = zero_q;
endmodule
